// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a valid/ready load port.
// A new word can be accepted on a word's last-bit cycle, so consecutive words go out with no gap.
`timescale 1ns/1ps
module piso_serializer #(
  parameter int   WIDTH      = 4,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_l,
  input  logic [WIDTH-1:0] Parallel_In,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  output logic             Serial_Out,
  output logic             Serial_Valid,
  output logic             Frame_Start,
  output logic             Frame_Done,
  output logic             Busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic             out_next, valid_next, start_next, done_next;
  logic             last_bit, accept;

  assign last_bit   = (state == SHIFT) && (cnt == LAST);
  // Ready is gated by reset so nothing can be accepted while the block is held in reset.
  assign Load_Ready = Rst_l && ((state == IDLE) || last_bit);
  assign accept     = Load_Valid && Load_Ready;

  // The shift register holds the word as loaded; Serial_Out is a separate
  // register so it can sit at IDLE_LEVEL between words.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sreg_next  = sreg;
    out_next   = IDLE_LEVEL;
    valid_next = 1'b0;
    start_next = 1'b0;
    done_next  = 1'b0;
    if (accept) begin
      state_next = SHIFT;
      cnt_next   = '0;
      sreg_next  = Parallel_In;
      out_next   = MSB_FIRST ? Parallel_In[WIDTH-1] : Parallel_In[0];
      valid_next = 1'b1;
      start_next = 1'b1;
    end else if (state == SHIFT && !last_bit) begin
      cnt_next   = cnt + CW'(1);
      sreg_next  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      out_next   = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
      valid_next = 1'b1;
      done_next  = (cnt_next == LAST);
    end else if (last_bit) begin
      state_next = IDLE;
      cnt_next   = '0;
      sreg_next  = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      state        <= IDLE;
      cnt          <= '0;
      sreg         <= '0;
      Serial_Out   <= IDLE_LEVEL;
      Serial_Valid <= 1'b0;
      Frame_Start  <= 1'b0;
      Frame_Done   <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      sreg         <= sreg_next;
      Serial_Out   <= out_next;
      Serial_Valid <= valid_next;
      Frame_Start  <= start_next;
      Frame_Done   <= done_next;
      Busy         <= valid_next;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a 4-bit MSB-first instance driven from a vector
// table plus hand sequences, and an 8-bit LSB-first instance with a high idle level.
`timescale 1ns/1ps
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_l = 1'b1;
  logic [3:0] din4 = '0;
  logic       valid4 = 1'b0;
  logic       ready4, out4, sv4, fs4, fd4, busy4;
  logic [7:0] din8 = '0;
  logic       valid8 = 1'b0;
  logic       ready8, out8, sv8, fs8, fd8, busy8;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] rx;

  typedef struct {
    logic       valid;
    logic [3:0] din;
    logic       ready;
    logic       out;
    logic       sv;
    logic       fs;
    logic       fd;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut4 (
    .Clk(clk), .Rst_l(rst_l), .Parallel_In(din4), .Load_Valid(valid4),
    .Load_Ready(ready4), .Serial_Out(out4), .Serial_Valid(sv4),
    .Frame_Start(fs4), .Frame_Done(fd4), .Busy(busy4)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut8 (
    .Clk(clk), .Rst_l(rst_l), .Parallel_In(din8), .Load_Valid(valid8),
    .Load_Ready(ready8), .Serial_Out(out8), .Serial_Valid(sv8),
    .Frame_Start(fs8), .Frame_Done(fd8), .Busy(busy8)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d);
    valid4 = v;
    din4   = d;
  endtask

  function automatic void addVec(input logic v, input logic [3:0] d, input logic rdy,
                                 input logic o, input logic s, input logic f, input logic e,
                                 input logic b);
    vec_t x;
    x.valid = v; x.din = d; x.ready = rdy; x.out = o; x.sv = s; x.fs = f; x.fd = e; x.busy = b;
    vecs.push_back(x);
  endfunction

  // Ready is checked before the edge; the registered outputs just after it.
  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].din);
      checkOutput($sformatf("row%0d ready", i), {7'b0, ready4}, {7'b0, vecs[i].ready});
      tick();
      if (sv4) rx = {rx[2:0], out4};
      checkOutput($sformatf("row%0d out", i),  {7'b0, out4},  {7'b0, vecs[i].out});
      checkOutput($sformatf("row%0d sv", i),   {7'b0, sv4},   {7'b0, vecs[i].sv});
      checkOutput($sformatf("row%0d fs", i),   {7'b0, fs4},   {7'b0, vecs[i].fs});
      checkOutput($sformatf("row%0d fd", i),   {7'b0, fd4},   {7'b0, vecs[i].fd});
      checkOutput($sformatf("row%0d busy", i), {7'b0, busy4}, {7'b0, vecs[i].busy});
    end
  endtask

  initial begin
    // valid din ready | out sv fs fd busy
    // basic 4'hA
    addVec(1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    addVec(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // back-to-back 4'h9 then 4'h6
    addVec(1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    addVec(1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    addVec(1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    addVec(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // back-pressure: 4'h3, Parallel_In zeroed mid-word, then 4'hC waits for ready
    addVec(1'b1, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    addVec(1'b1, 4'hC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    addVec(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state of both instances.
    #2 rst_l = 1'b0;
    #1;
    checkOutput("reset out4",   {7'b0, out4},   8'h0);
    checkOutput("reset sv4",    {7'b0, sv4},    8'h0);
    checkOutput("reset busy4",  {7'b0, busy4},  8'h0);
    checkOutput("reset fs4",    {7'b0, fs4},    8'h0);
    checkOutput("reset fd4",    {7'b0, fd4},    8'h0);
    checkOutput("reset ready4", {7'b0, ready4}, 8'h0);
    checkOutput("reset out8",   {7'b0, out8},   8'h1);
    checkOutput("reset ready8", {7'b0, ready8}, 8'h0);
    tick();
    tick();
    rst_l = 1'b1;
    #1;
    checkOutput("post-reset ready4", {7'b0, ready4}, 8'h1);
    checkOutput("post-reset ready8", {7'b0, ready8}, 8'h1);

    // LSB-first, idle high: 8'h01 goes out as 1 then seven 0s.
    valid8 = 1'b1;
    din8   = 8'h01;
    tick();
    valid8 = 1'b0;
    din8   = 8'hFF;
    checkOutput("lsb bit0 out", {7'b0, out8}, 8'h1);
    checkOutput("lsb bit0 fs",  {7'b0, fs8},  8'h1);
    checkOutput("lsb bit0 sv",  {7'b0, sv8},  8'h1);
    for (int k = 1; k < 8; k++) begin
      tick();
      checkOutput($sformatf("lsb bit%0d out", k), {7'b0, out8}, 8'h0);
      checkOutput($sformatf("lsb bit%0d sv", k),  {7'b0, sv8},  8'h1);
      checkOutput($sformatf("lsb bit%0d fd", k),  {7'b0, fd8},  {7'b0, (k == 7)});
    end
    tick();
    checkOutput("lsb idle out",  {7'b0, out8},  8'h1);
    checkOutput("lsb idle sv",   {7'b0, sv8},   8'h0);
    checkOutput("lsb idle busy", {7'b0, busy8}, 8'h0);

    rx = '0;
    runRows(0, 5);
    checkOutput("rx after basic", {4'b0, rx}, 8'h0A);
    runRows(6, 14);
    checkOutput("rx after b2b", {4'b0, rx}, 8'h06);
    runRows(15, 23);
    checkOutput("rx after backpressure", {4'b0, rx}, 8'h0C);

    // Reset two bits into 4'hF aborts the word at once.
    applyStimulus(1'b1, 4'hF);
    tick();
    checkOutput("abort bit0", {7'b0, out4}, 8'h1);
    applyStimulus(1'b0, 4'h0);
    tick();
    checkOutput("abort bit1", {7'b0, out4}, 8'h1);
    #1 rst_l = 1'b0;
    #1;
    checkOutput("abort out",   {7'b0, out4},   8'h0);
    checkOutput("abort sv",    {7'b0, sv4},    8'h0);
    checkOutput("abort busy",  {7'b0, busy4},  8'h0);
    checkOutput("abort fd",    {7'b0, fd4},    8'h0);
    checkOutput("abort ready", {7'b0, ready4}, 8'h0);
    tick();
    checkOutput("abort held fd", {7'b0, fd4}, 8'h0);
    checkOutput("abort held sv", {7'b0, sv4}, 8'h0);
    rst_l = 1'b1;
    #1;
    checkOutput("abort release ready", {7'b0, ready4}, 8'h1);
    applyStimulus(1'b1, 4'h5);
    tick();
    checkOutput("after abort bit0", {7'b0, out4}, 8'h0);
    checkOutput("after abort fs",   {7'b0, fs4},  8'h1);
    applyStimulus(1'b0, 4'h0);
    tick();
    checkOutput("after abort bit1", {7'b0, out4}, 8'h1);
    tick();
    checkOutput("after abort bit2", {7'b0, out4}, 8'h0);
    tick();
    checkOutput("after abort bit3", {7'b0, out4}, 8'h1);
    checkOutput("after abort fd",   {7'b0, fd4},  8'h1);
    tick();
    checkOutput("after abort idle sv", {7'b0, sv4}, 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
